cam_ctrl: RTL and testbench

//  Command sequencer for the ram_dp-based CAM (data-indexed bitmap RAM, bit=0 => entry present).

---
 rtl/cam_pkg.sv | 34 +++
 rtl/cam_if.sv | 26 ++
 rtl/cam_prio_enc.sv | 18 +
 rtl/cam_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cam_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared encodings for the CAM command sequencer.
// Op codes, status codes, FSM states and default sizes.
package cam_pkg;

  localparam int CAM_DW = 8;
  localparam int CAM_AW = 2;
  localparam int CAM_N  = 1 << CAM_AW;
  localparam int CAM_CW = CAM_AW + 1;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_WRITE  = 2'b01,
    OP_ERASE  = 2'b10,
    OP_ADD    = 2'b11
  } cam_op_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_MISS   = 2'b01,
    ST_FULL   = 2'b10,
    ST_NOSLOT = 2'b11
  } cam_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LK_ISSUE,
    S_LK_WAIT,
    S_ERASE_OLD,
    S_WR_NEW,
    S_ERASE_SLOT,
    S_RESP
  } cam_state_e;

endpackage

// File: rtl/cam_if.sv
// Command/response bundle between key management and the CAM sequencer.
// master = requester, slave = cam_ctrl.
interface cam_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [1:0]    rsp_status;
  logic [AW-1:0] rsp_addr;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_status, rsp_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_hit, rsp_status, rsp_addr
  );
endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit flag.
// Used for lookup matches and free-slot search.
module cam_prio_enc #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end
endmodule

// File: rtl/cam_ctrl.sv
// CAM command sequencer: serialises lookup/write/erase/add onto one ram_dp.
// Valid bitmap and shadow keys mask stale RAM bits.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DW,
  parameter int ADDR_WIDTH = CAM_AW
) (
  input  logic                        clk,
  input  logic                        rst,
  cam_if.slave                        bus,
  output logic [ADDR_WIDTH:0]         count,
  output logic                        full,
  output logic                        ram_write,
  output logic                        ram_erase,
  output logic [ADDR_WIDTH-1:0]       ram_a_addr,
  output logic [DATA_WIDTH-1:0]       ram_a_din,
  output logic [DATA_WIDTH-1:0]       ram_b_din,
  input  logic [(1<<ADDR_WIDTH)-1:0]  ram_b_dout
);
  localparam int N  = 1 << ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;

  cam_state_e state, state_nx;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic [N-1:0]          valid;
  logic [DATA_WIDTH-1:0] shadow [N];

  logic [N-1:0]          match;
  logic [ADDR_WIDTH-1:0] hit_idx, free_idx;
  logic                  hit_any, free_any;

  logic                  accept;
  logic                  wr_nx, er_nx, rsp_set;
  logic [ADDR_WIDTH-1:0] a_addr_nx, raddr_nx, slot_sel;
  logic [DATA_WIDTH-1:0] a_din_nx;
  cam_status_e           st_nx;
  logic [CW-1:0]         cnt_inc;

  // Stale RAM bits of invalid slots never count as matches
  assign match   = ~ram_b_dout & valid;
  assign accept  = bus.cmd_valid & bus.cmd_ready;
  assign cnt_inc = count + 1'b1;
  assign slot_sel = (bus.cmd_op == OP_ADD) ? free_idx : bus.cmd_addr;

  cam_prio_enc #(.N(N), .W(ADDR_WIDTH)) u_hit (
    .req (match),
    .idx (hit_idx),
    .any (hit_any)
  );

  cam_prio_enc #(.N(N), .W(ADDR_WIDTH)) u_free (
    .req (~valid),
    .idx (free_idx),
    .any (free_any)
  );

  always_comb begin
    state_nx  = state;
    wr_nx     = 1'b0;
    er_nx     = 1'b0;
    a_addr_nx = ram_a_addr;
    a_din_nx  = ram_a_din;
    rsp_set   = 1'b0;
    st_nx     = ST_OK;
    raddr_nx  = '0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (cam_op_e'(bus.cmd_op))
            OP_LOOKUP: state_nx = S_LK_ISSUE;
            OP_WRITE: begin
              a_addr_nx = bus.cmd_addr;
              if (valid[bus.cmd_addr]) begin
                state_nx = S_ERASE_OLD;
                er_nx    = 1'b1;
                a_din_nx = shadow[bus.cmd_addr];
              end else begin
                state_nx = S_WR_NEW;
                wr_nx    = 1'b1;
                a_din_nx = bus.cmd_data;
              end
            end
            OP_ERASE: begin
              if (valid[bus.cmd_addr]) begin
                state_nx  = S_ERASE_SLOT;
                er_nx     = 1'b1;
                a_addr_nx = bus.cmd_addr;
                a_din_nx  = shadow[bus.cmd_addr];
              end else begin
                state_nx = S_RESP;
                rsp_set  = 1'b1;
                st_nx    = ST_NOSLOT;
              end
            end
            OP_ADD: begin
              if (free_any) begin
                state_nx  = S_WR_NEW;
                wr_nx     = 1'b1;
                a_addr_nx = free_idx;
                a_din_nx  = bus.cmd_data;
              end else begin
                state_nx = S_RESP;
                rsp_set  = 1'b1;
                st_nx    = ST_FULL;
              end
            end
          endcase
        end
      end
      S_LK_ISSUE: state_nx = S_LK_WAIT;
      S_LK_WAIT: begin
        state_nx = S_RESP;
        rsp_set  = 1'b1;
        st_nx    = hit_any ? ST_OK : ST_MISS;
        raddr_nx = hit_any ? hit_idx : '0;
      end
      S_ERASE_OLD: begin
        state_nx  = S_WR_NEW;
        wr_nx     = 1'b1;
        a_addr_nx = addr_q;
        a_din_nx  = key_q;
      end
      S_WR_NEW, S_ERASE_SLOT: begin
        state_nx = S_RESP;
        rsp_set  = 1'b1;
        raddr_nx = addr_q;
      end
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
      key_q          <= '0;
      valid          <= '0;
      count          <= '0;
      full           <= 1'b0;
      ram_write      <= 1'b0;
      ram_erase      <= 1'b0;
      ram_a_addr     <= '0;
      ram_a_din      <= '0;
      ram_b_din      <= '0;
      bus.cmd_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_hit    <= 1'b0;
      bus.rsp_status <= '0;
      bus.rsp_addr   <= '0;
    end else begin
      ram_write     <= wr_nx;
      ram_erase     <= er_nx;
      ram_a_addr    <= a_addr_nx;
      ram_a_din     <= a_din_nx;
      bus.cmd_ready <= (state_nx == S_IDLE);
      bus.rsp_valid <= rsp_set;
      if (rsp_set) begin
        bus.rsp_status <= st_nx;
        bus.rsp_hit    <= (st_nx == ST_OK);
        bus.rsp_addr   <= raddr_nx;
      end
      if (accept) begin
        addr_q <= slot_sel;
        key_q  <= bus.cmd_data;
        if (bus.cmd_op == OP_LOOKUP) ram_b_din <= bus.cmd_data;
      end
      if (state == S_WR_NEW) begin
        valid[addr_q] <= 1'b1;
        if (!valid[addr_q]) begin
          count <= cnt_inc;
          full  <= (cnt_inc == CW'(N));
        end
      end
      if (state == S_ERASE_SLOT) begin
        valid[addr_q] <= 1'b0;
        count         <= count - 1'b1;
        full          <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WR_NEW) shadow[addr_q] <= key_q;
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: directed spot checks plus random commands
// against a slot/key model, with a bitmap RAM stand-in for ram_dp.
module tb_cam_ctrl;
  import cam_pkg::*;

  localparam int DW = CAM_DW;
  localparam int AW = CAM_AW;
  localparam int N  = CAM_N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_rst = 1'b1;
  always #5 clk = ~clk;

  cam_if #(.DW(DW), .AW(AW)) bus ();

  logic [CAM_CW-1:0] count;
  logic              full, ram_write, ram_erase;
  logic [AW-1:0]     ram_a_addr;
  logic [DW-1:0]     ram_a_din, ram_b_din;
  logic [N-1:0]      ram_b_dout;

  cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .count      (count),
    .full       (full),
    .ram_write  (ram_write),
    .ram_erase  (ram_erase),
    .ram_a_addr (ram_a_addr),
    .ram_a_din  (ram_a_din),
    .ram_b_din  (ram_b_din),
    .ram_b_dout (ram_b_dout)
  );

  // ram_dp stand-in: one N-bit word per key, bit 0 = present; reset empties it
  logic [N-1:0] mem [256];
  always @(posedge clk or posedge ram_rst) begin
    if (ram_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '1;
      ram_b_dout <= '1;
    end else begin
      if (ram_write) mem[ram_a_din][ram_a_addr] <= 1'b0;
      if (ram_erase) mem[ram_a_din][ram_a_addr] <= 1'b1;
      ram_b_dout <= mem[ram_b_din];
    end
  end

  int cyc = 0;
  int n_wr = 0, n_er = 0, wr_cyc = 0, er_cyc = 0;
  logic [DW-1:0] wr_din, er_din;
  logic [AW-1:0] wr_addr, er_addr;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_write) begin
      n_wr <= n_wr + 1; wr_din <= ram_a_din;
      wr_addr <= ram_a_addr; wr_cyc <= cyc;
    end
    if (ram_erase) begin
      n_er <= n_er + 1; er_din <= ram_a_din;
      er_addr <= ram_a_addr; er_cyc <= cyc;
    end
  end

  int vectors = 0, errs = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: which key lives in which valid slot
  bit            m_valid [N];
  logic [DW-1:0] m_key [N];
  int            m_count = 0;
  bit            pending = 0;
  bit            chk_en = 0;
  int            exp_due, post_count;
  logic [1:0]    exp_st;
  logic [AW-1:0] exp_addr;
  logic [1:0]    last_st;
  logic [AW-1:0] last_addr;

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      bit due;
      due = pending && (cyc == exp_due);
      chk("cmd_ready", bus.cmd_ready, !pending);
      chk("rsp_valid", bus.rsp_valid, due);
      if (bus.rsp_valid) begin
        last_st = bus.rsp_status;
        last_addr = bus.rsp_addr;
      end
      if (due) begin
        chk("rsp_status", bus.rsp_status, exp_st);
        chk("rsp_hit", bus.rsp_hit, exp_st == ST_OK);
        chk("rsp_addr", bus.rsp_addr, exp_addr);
        m_count = post_count;
        pending = 0;
      end
      chk("count", count, m_count);
      chk("full", full, m_count == N);
      chk("wr_er_excl", ram_write & ram_erase, 0);
    end
  end

  task automatic do_cmd(input cam_op_e op, input int a, input logic [DW-1:0] d);
    int lat, ra, g;
    logic [1:0] st;
    last_st = 2'bxx;
    last_addr = 'x;
    @(negedge clk);
    g = 0;
    while (!bus.cmd_ready && g < 20) begin @(negedge clk); g++; end
    st = ST_OK; ra = 0; lat = 2;
    case (op)
      OP_LOOKUP: begin
        lat = 3; st = ST_MISS;
        for (int i = N - 1; i >= 0; i--)
          if (m_valid[i] && m_key[i] == d) begin st = ST_OK; ra = i; end
      end
      OP_WRITE: begin
        lat = m_valid[a] ? 3 : 2; ra = a;
        m_valid[a] = 1; m_key[a] = d;
      end
      OP_ERASE: begin
        if (m_valid[a]) begin ra = a; m_valid[a] = 0; end
        else begin st = ST_NOSLOT; lat = 1; end
      end
      OP_ADD: begin
        st = ST_FULL; lat = 1;
        for (int i = N - 1; i >= 0; i--)
          if (!m_valid[i]) begin st = ST_OK; lat = 2; ra = i; end
        if (st == ST_OK) begin m_valid[ra] = 1; m_key[ra] = d; end
      end
      default: ;
    endcase
    post_count = 0;
    for (int i = 0; i < N; i++) post_count += int'(m_valid[i]);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_addr = AW'(a);
    bus.cmd_data = d;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = AW'($urandom_range(0, N - 1));
    bus.cmd_data = DW'($urandom);
    exp_st = st;
    exp_addr = AW'(ra);
    exp_due = cyc + lat - 1;
    pending = 1;
    g = 0;
    while (pending && g < 20) begin @(negedge clk); g++; end
    if (pending) begin
      chk("rsp_timeout", 1, 0);
      pending = 0;
    end
  endtask

  task automatic expect_rsp(input string name, input logic [1:0] st,
                            input logic [AW-1:0] a);
    chk({name, "_st"}, last_st, st);
    chk({name, "_addr"}, last_addr, a);
  endtask

  int n0, e0;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_addr = '0;
    bus.cmd_data = '0;
    for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_key[i] = '0; end
    #12;
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_erase", ram_erase, 0);
    chk("rst_b_din", ram_b_din, 0);
    @(negedge clk);
    rst = 1'b0;
    ram_rst = 1'b0;
    chk_en = 1;

    do_cmd(OP_LOOKUP, 0, 8'h00);
    expect_rsp("lk_empty", ST_MISS, 0);
    for (int i = 0; i < N; i++) begin
      do_cmd(OP_ADD, 0, DW'(8'h41 + i));
      expect_rsp("add_fill", ST_OK, AW'(i));
    end
    chk("full_after_fill", full, 1);
    n0 = n_wr;
    do_cmd(OP_ADD, 0, 8'h45);
    expect_rsp("add_full", ST_FULL, 0);
    chk("add_full_no_write", n_wr, n0);

    n0 = n_wr; e0 = n_er;
    do_cmd(OP_WRITE, 1, 8'h99);
    expect_rsp("ow", ST_OK, 1);
    chk("ow_erase_n", n_er - e0, 1);
    chk("ow_erase_din", er_din, 8'h42);
    chk("ow_erase_addr", er_addr, 1);
    chk("ow_write_n", n_wr - n0, 1);
    chk("ow_write_din", wr_din, 8'h99);
    chk("ow_write_addr", wr_addr, 1);
    chk("ow_order", er_cyc < wr_cyc, 1);
    do_cmd(OP_LOOKUP, 0, 8'h42);
    expect_rsp("lk_old", ST_MISS, 0);
    do_cmd(OP_LOOKUP, 0, 8'h99);
    expect_rsp("lk_new", ST_OK, 1);

    do_cmd(OP_ERASE, 2, 8'h00);
    expect_rsp("er2", ST_OK, 2);
    chk("er2_count", count, 3);
    chk("er2_din", er_din, 8'h43);
    do_cmd(OP_ERASE, 2, 8'h00);
    expect_rsp("er2_again", ST_NOSLOT, 0);
    do_cmd(OP_ADD, 0, 8'h55);
    expect_rsp("add_reuse", ST_OK, 2);

    do_cmd(OP_WRITE, 3, 8'h10);
    do_cmd(OP_WRITE, 0, 8'h10);
    do_cmd(OP_LOOKUP, 0, 8'h10);
    expect_rsp("dup_lowest", ST_OK, 0);
    do_cmd(OP_ERASE, 0, 8'h00);
    do_cmd(OP_LOOKUP, 0, 8'h10);
    expect_rsp("dup_next", ST_OK, 3);

    for (int k = 0; k < 150; k++)
      do_cmd(cam_op_e'($urandom_range(0, 3)), $urandom_range(0, N - 1),
             DW'(8'h10 + $urandom_range(0, 5)));

    // Abandon an ADD mid-write with an async reset
    do_cmd(OP_ERASE, 0, 8'h00);
    @(negedge clk);
    chk_en = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_ADD;
    bus.cmd_data = 8'hA5;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("abort_in_wr_new", ram_write, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_ram_write", ram_write, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_count", count, 0);
    chk("abort_full", full, 0);
    chk("abort_ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_count = 0;
    pending = 0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    do_cmd(OP_LOOKUP, 0, 8'hA5);
    expect_rsp("abort_lookup", ST_MISS, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
